// File: rtl/debug_uart_tx.sv
// Snapshots the seven CPU debug bytes and sends them as one 8N1 UART frame:
// sync byte, the seven captured bytes, then their mod-256 sum.
module debug_uart_tx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       snap,
   input  logic [7:0] debug_port1,
   input  logic [7:0] debug_port2,
   input  logic [7:0] debug_port3,
   input  logic [7:0] debug_port4,
   input  logic [7:0] debug_port5,
   input  logic [7:0] debug_port6,
   input  logic [7:0] debug_port7,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [7:0] drop_count
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [3:0]       byte_q, byte_d;
   logic [7:0]       port_q [1:7];
   logic [7:0]       sum_q, sum_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic [7:0]       drop_q, drop_d;
   logic             cnt_last;
   logic             accept;
   logic [7:0]       cur_byte;

   // snap is a request with no ready: taken only when idle, otherwise counted as a drop.
   assign cnt_last = (cnt_q == CNT_LAST);
   assign accept   = (state_q == ST_IDLE) && snap;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         sum_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         drop_q  <= '0;
         for (int i = 1; i <= 7; i++) port_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         sum_q   <= sum_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
         if (accept) begin
            port_q[1] <= debug_port1;
            port_q[2] <= debug_port2;
            port_q[3] <= debug_port3;
            port_q[4] <= debug_port4;
            port_q[5] <= debug_port5;
            port_q[6] <= debug_port6;
            port_q[7] <= debug_port7;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      case (state_q)
         ST_IDLE: begin
            if (snap) begin
               state_d = ST_START;
               cnt_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
            end
         end
         ST_START: begin
            if (cnt_last) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (bit_q == 3'd7) state_d = ST_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (byte_q == 4'd8) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_START;
                  byte_d  = byte_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // tx is computed from the next state so the registered line changes on the same edge as the FSM.
   always_comb begin
      case (byte_d)
         4'd0:    cur_byte = SYNC_BYTE;
         4'd1:    cur_byte = port_q[1];
         4'd2:    cur_byte = port_q[2];
         4'd3:    cur_byte = port_q[3];
         4'd4:    cur_byte = port_q[4];
         4'd5:    cur_byte = port_q[5];
         4'd6:    cur_byte = port_q[6];
         4'd7:    cur_byte = port_q[7];
         default: cur_byte = sum_q;
      endcase
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = cur_byte[bit_d];
         default:  tx_d = 1'b1;
      endcase
      done_d = (state_q == ST_STOP) && cnt_last && (byte_q == 4'd8);
      drop_d = drop_q;
      if (snap && (state_q != ST_IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      sum_d = sum_q;
      if (accept) sum_d = debug_port1 + debug_port2 + debug_port3 + debug_port4
                        + debug_port5 + debug_port6 + debug_port7;
   end

   assign tx         = tx_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign drop_count = drop_q;

endmodule
